ama_riscv_mem_arbiter: RTL and testbench

Shares the single 128-bit main-memory port between the instruction cache (line fills) and the data cache (line fills and line writebacks). Each granted request is sequenced into MEM_TRANSFERS_PER_CL (4) consecutive beat requests, and read beats are steered back to the owner. The block sits between both cache controllers and the memory model/controller. It serves one cache-line transaction at a time, with round-robin arbitration between the two caches.

---
 rtl/ama_riscv_mem_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_ama_riscv_mem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ama_riscv_mem_arbiter.sv
// ama_riscv_mem_arbiter
// Shares one main-memory port between the icache (line fills) and the dcache
// (line fills and writebacks). One line transaction is in flight at a time.
// Each accepted line is split into BEATS consecutive beat requests, and read
// beats are steered back to the cache that owns the transaction.
// Arbitration is round-robin between the two caches.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   ic_req_*            : icache line-read request (valid/ready/addr)
//   ic_rsp_*            : read beats returned to the icache (valid/data/last)
//   dc_req_*            : dcache request (valid/ready/addr/rtype/wdata line)
//   dc_rsp_*            : read beats returned to the dcache (valid/data/last)
//   mem_req_*           : beat requests to memory (valid/ready/addr/we/wdata)
//   mem_rsp_*           : in-order read beats from memory (valid/data)
//   busy                : a line transaction is in flight
//   err_unexp_rsp       : sticky flag, memory response seen outside a read
module ama_riscv_mem_arbiter #(
   parameter int AW    = 12,
   parameter int DW    = 128,
   parameter int BEATS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ic_req_valid,
   output logic                ic_req_ready,
   input  logic [AW-1:0]       ic_req_addr,
   output logic                ic_rsp_valid,
   output logic [DW-1:0]       ic_rsp_data,
   output logic                ic_rsp_last,
   input  logic                dc_req_valid,
   output logic                dc_req_ready,
   input  logic [AW-1:0]       dc_req_addr,
   input  logic                dc_req_rtype,
   input  logic [DW*BEATS-1:0] dc_req_wdata,
   output logic                dc_rsp_valid,
   output logic [DW-1:0]       dc_rsp_data,
   output logic                dc_rsp_last,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [AW-1:0]       mem_req_addr,
   output logic                mem_req_we,
   output logic [DW-1:0]       mem_req_wdata,
   input  logic                mem_rsp_valid,
   input  logic [DW-1:0]       mem_rsp_data,
   output logic                busy,
   output logic                err_unexp_rsp
);

   localparam int LW = $clog2(BEATS);
   localparam int CW = LW + 1;
   localparam logic DMEM_WRITE = 1'b1;

   function automatic logic is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

   generate
      if (!is_pow2(BEATS) || (BEATS < 2)) begin : g_beats_check
         $error("BEATS must be a power of 2 and at least 2");
      end
   endgenerate

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RD = 2'd1, ST_WR = 2'd2} state_t;
   typedef enum logic {OWN_IC = 1'b0, OWN_DC = 1'b1} owner_t;

   state_t          state_r, state_nxt_s;
   owner_t          owner_r, last_grant_r;
   logic [AW-1:0]   base_addr_r;
   logic [CW-1:0]   iss_cnt_r, rsp_cnt_r;
   logic [DW-1:0]   wbuf_r [BEATS];
   logic            err_r;

   logic            ic_win_s, dc_win_s, accept_s;
   logic            iss_hs_s, rsp_fwd_s, rsp_last_s;
   logic [LW-1:0]   iss_idx_s;
   logic [AW-1:0]   win_addr_s;

   assign iss_idx_s     = iss_cnt_r[LW-1:0];
   assign rsp_last_s    = (rsp_cnt_r == CW'(BEATS - 1));
   assign accept_s      = ic_win_s || dc_win_s;
   assign iss_hs_s      = mem_req_valid && mem_req_ready;
   // Masking keeps the whole address in use while dropping the beat bits.
   assign win_addr_s    = (ic_win_s ? ic_req_addr : dc_req_addr) & ~AW'(BEATS - 1);
   assign ic_rsp_data   = mem_rsp_data;
   assign dc_rsp_data   = mem_rsp_data;
   assign mem_req_addr  = base_addr_r | {{(AW-LW){1'b0}}, iss_idx_s};
   assign mem_req_wdata = wbuf_r[iss_idx_s];
   assign busy          = (state_r != ST_IDLE);
   assign err_unexp_rsp = err_r;

   // Arbitration, beat issue, response steering and next-state logic.
   always_comb begin
      state_nxt_s   = state_r;
      ic_win_s      = 1'b0;
      dc_win_s      = 1'b0;
      rsp_fwd_s     = 1'b0;
      mem_req_valid = 1'b0;
      mem_req_we    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            // On a tie the cache that was not granted last time wins.
            ic_win_s = ic_req_valid && (!dc_req_valid || (last_grant_r == OWN_DC));
            dc_win_s = dc_req_valid && !ic_win_s;
            if (ic_win_s) begin
               state_nxt_s = ST_RD;
            end else if (dc_win_s) begin
               state_nxt_s = (dc_req_rtype == DMEM_WRITE) ? ST_WR : ST_RD;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RD: begin
            mem_req_valid = (iss_cnt_r < CW'(BEATS));
            rsp_fwd_s     = mem_rsp_valid;
            if (mem_rsp_valid && rsp_last_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_RD;
            end
         end
         ST_WR: begin
            mem_req_valid = (iss_cnt_r < CW'(BEATS));
            mem_req_we    = 1'b1;
            if (mem_req_valid && mem_req_ready && (iss_cnt_r == CW'(BEATS - 1))) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_WR;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Per-cache handshake and response outputs derived from the decisions above.
   always_comb begin
      ic_req_ready = ic_win_s;
      dc_req_ready = dc_win_s;
      ic_rsp_valid = rsp_fwd_s && (owner_r == OWN_IC);
      dc_rsp_valid = rsp_fwd_s && (owner_r == OWN_DC);
      ic_rsp_last  = ic_rsp_valid && rsp_last_s;
      dc_rsp_last  = dc_rsp_valid && rsp_last_s;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Transaction context: owner, fairness pointer, base address and beat counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_r      <= OWN_IC;
         last_grant_r <= OWN_DC;
         base_addr_r  <= '0;
         iss_cnt_r    <= '0;
         rsp_cnt_r    <= '0;
      end else if (accept_s) begin
         owner_r      <= ic_win_s ? OWN_IC : OWN_DC;
         last_grant_r <= ic_win_s ? OWN_IC : OWN_DC;
         base_addr_r  <= win_addr_s;
         iss_cnt_r    <= '0;
         rsp_cnt_r    <= '0;
      end else begin
         if (iss_hs_s) begin
            iss_cnt_r <= iss_cnt_r + CW'(1);
         end
         if (rsp_fwd_s) begin
            rsp_cnt_r <= rsp_cnt_r + CW'(1);
         end
      end
   end

   // Writeback line buffer, captured only when a dcache writeback is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BEATS; i++) begin
            wbuf_r[i] <= '0;
         end
      end else if (dc_win_s && (dc_req_rtype == DMEM_WRITE)) begin
         for (int i = 0; i < BEATS; i++) begin
            wbuf_r[i] <= dc_req_wdata[i*DW +: DW];
         end
      end
   end

   // Sticky error: a memory response outside a read is dropped and flagged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_r <= 1'b0;
      end else if (mem_rsp_valid && (state_r != ST_RD)) begin
         err_r <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ama_riscv_mem_arbiter.sv
// Directed self-checking bench for ama_riscv_mem_arbiter.
// A small in-bench memory answers each read handshake with one beat in the
// following cycle; handshakes, returned beats and grants are logged and then
// compared against hand-computed values.
module tb_ama_riscv_mem_arbiter;

   localparam int AW = 12;
   localparam int DW = 128;
   localparam int BEATS = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              ic_req_valid, ic_req_ready;
   logic [AW-1:0]     ic_req_addr;
   logic              ic_rsp_valid, ic_rsp_last;
   logic [DW-1:0]     ic_rsp_data;
   logic              dc_req_valid, dc_req_ready, dc_req_rtype;
   logic [AW-1:0]     dc_req_addr;
   logic [DW*BEATS-1:0] dc_req_wdata;
   logic              dc_rsp_valid, dc_rsp_last;
   logic [DW-1:0]     dc_rsp_data;
   logic              mem_req_valid, mem_req_ready, mem_req_we;
   logic [AW-1:0]     mem_req_addr;
   logic [DW-1:0]     mem_req_wdata;
   logic              mem_rsp_valid;
   logic [DW-1:0]     mem_rsp_data;
   logic              busy, err_unexp_rsp;

   ama_riscv_mem_arbiter #(.AW(AW), .DW(DW), .BEATS(BEATS)) dut (
      .clk(clk), .rst(rst),
      .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
      .ic_rsp_valid(ic_rsp_valid), .ic_rsp_data(ic_rsp_data), .ic_rsp_last(ic_rsp_last),
      .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_addr(dc_req_addr),
      .dc_req_rtype(dc_req_rtype), .dc_req_wdata(dc_req_wdata),
      .dc_rsp_valid(dc_rsp_valid), .dc_rsp_data(dc_rsp_data), .dc_rsp_last(dc_rsp_last),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .busy(busy), .err_unexp_rsp(err_unexp_rsp)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc_n  = 0;
   bit persist = 1'b0;

   logic [AW-1:0] hs_addr[$];
   logic          hs_we[$];
   logic [DW-1:0] hs_wdata[$];
   int            hs_cyc[$];
   logic [DW-1:0] ic_d[$], dc_d[$];
   logic          ic_l[$], dc_l[$];
   int            acc_who[$], acc_cyc[$];
   logic [DW-1:0] pend[$];
   logic          rdy_pat[$];

   bit            stalled = 1'b0;
   logic [AW-1:0] st_addr;
   logic          st_we;
   logic [DW-1:0] st_wd;

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk_i(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_w(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Memory contents: line 0x010 holds 0xA0..0xA3, other lines are offset by 0x100 per line.
   function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
      logic [9:0] line;
      line = a[AW-1:2] - 10'd4;
      return DW'(8'hA0 + {6'd0, a[1:0]}) | (DW'(line) << 8);
   endfunction

   // One clock cycle: observe at the falling edge, then update stimulus just after the rising edge.
   task automatic cyc();
      bit ic_acc, dc_acc;
      @(negedge clk);
      if (stalled) begin
         chk_b("stall_valid", mem_req_valid, 1'b1);
         chk_i("stall_addr", int'(mem_req_addr), int'(st_addr));
         chk_b("stall_we", mem_req_we, st_we);
         chk_w("stall_wdata", mem_req_wdata, st_wd);
      end
      stalled = mem_req_valid && !mem_req_ready;
      st_addr = mem_req_addr;
      st_we   = mem_req_we;
      st_wd   = mem_req_wdata;
      if (mem_req_valid && mem_req_ready) begin
         hs_addr.push_back(mem_req_addr);
         hs_we.push_back(mem_req_we);
         hs_wdata.push_back(mem_req_wdata);
         hs_cyc.push_back(cyc_n);
         if (!mem_req_we) pend.push_back(memval(mem_req_addr));
      end
      if (ic_rsp_valid) begin
         ic_d.push_back(ic_rsp_data);
         ic_l.push_back(ic_rsp_last);
      end
      if (dc_rsp_valid) begin
         dc_d.push_back(dc_rsp_data);
         dc_l.push_back(dc_rsp_last);
      end
      ic_acc = ic_req_valid && ic_req_ready;
      dc_acc = dc_req_valid && dc_req_ready;
      if (ic_acc) begin acc_who.push_back(0); acc_cyc.push_back(cyc_n); end
      if (dc_acc) begin acc_who.push_back(1); acc_cyc.push_back(cyc_n); end
      @(posedge clk);
      #1;
      cyc_n++;
      if (!persist) begin
         if (ic_acc) ic_req_valid = 1'b0;
         if (dc_acc) begin dc_req_valid = 1'b0; dc_req_wdata = '0; end
      end
      mem_req_ready = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : 1'b1;
      if (pend.size() > 0) begin
         mem_rsp_valid = 1'b1;
         mem_rsp_data  = pend.pop_front();
      end else begin
         mem_rsp_valid = 1'b0;
         mem_rsp_data  = '0;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      ic_req_valid = 1'b0; ic_req_addr = '0;
      dc_req_valid = 1'b0; dc_req_addr = '0; dc_req_rtype = 1'b0; dc_req_wdata = '0;
      mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
      hs_addr.delete(); hs_we.delete(); hs_wdata.delete(); hs_cyc.delete();
      ic_d.delete(); dc_d.delete(); ic_l.delete(); dc_l.delete();
      acc_who.delete(); acc_cyc.delete(); pend.delete(); rdy_pat.delete();
      stalled = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc_n = 0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      for (int i = 0; i < budget; i++) begin
         cyc();
         if (busy === 1'b0) break;
      end
      chk_b({tag, "_idle_reached"}, busy, 1'b0);
   endtask

   initial begin
      logic [DW-1:0] q[4];
      rst = 1'b1;
      ic_req_valid = 1'b0; ic_req_addr = '0;
      dc_req_valid = 1'b0; dc_req_addr = '0; dc_req_rtype = 1'b0; dc_req_wdata = '0;
      mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
      #2;
      // Reset state
      chk_b("rst_busy", busy, 1'b0);
      chk_b("rst_mem_valid", mem_req_valid, 1'b0);
      chk_b("rst_ic_rsp_valid", ic_rsp_valid, 1'b0);
      chk_b("rst_dc_rsp_valid", dc_rsp_valid, 1'b0);
      chk_b("rst_ic_rsp_last", ic_rsp_last, 1'b0);
      chk_b("rst_dc_rsp_last", dc_rsp_last, 1'b0);
      chk_b("rst_err", err_unexp_rsp, 1'b0);
      chk_b("rst_ic_ready_idle", ic_req_ready, 1'b0);
      ic_req_valid = 1'b1;
      #1;
      chk_b("rst_ic_ready_follows_valid", ic_req_ready, 1'b1);
      ic_req_valid = 1'b0;
      do_reset();

      // Icache-only fill of line 0x010
      ic_req_valid = 1'b1; ic_req_addr = 12'h013;
      #1;
      chk_b("t1_ic_ready", ic_req_ready, 1'b1);
      chk_b("t1_dc_ready", dc_req_ready, 1'b0);
      wait_idle("t1", 30);
      chk_i("t1_accepts", acc_who.size(), 1);
      chk_i("t1_accept_cycle", acc_cyc[0], 0);
      chk_i("t1_idle_cycle", cyc_n, 6);
      chk_i("t1_hs_count", hs_addr.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk_i($sformatf("t1_hs_addr%0d", i), int'(hs_addr[i]), 16 + i);
         chk_b($sformatf("t1_hs_we%0d", i), hs_we[i], 1'b0);
         chk_i($sformatf("t1_hs_cyc%0d", i), hs_cyc[i], 1 + i);
      end
      chk_i("t1_ic_beats", ic_d.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk_w($sformatf("t1_ic_data%0d", i), ic_d[i], DW'(128'hA0 + i));
         chk_b($sformatf("t1_ic_last%0d", i), ic_l[i], (i == 3));
      end
      chk_i("t1_dc_beats", dc_d.size(), 0);

      // Persistent tie between both caches: grants alternate IC, DC, IC, DC
      do_reset();
      persist = 1'b1;
      ic_req_valid = 1'b1; ic_req_addr = 12'h020;
      dc_req_valid = 1'b1; dc_req_addr = 12'h031; dc_req_rtype = 1'b0;
      for (int i = 0; i < 60; i++) begin
         cyc();
         if (acc_who.size() >= 4) break;
      end
      persist = 1'b0;
      ic_req_valid = 1'b0; dc_req_valid = 1'b0;
      wait_idle("t2", 30);
      chk_i("t2_accepts", acc_who.size(), 4);
      chk_i("t2_who0", acc_who[0], 0);
      chk_i("t2_who1", acc_who[1], 1);
      chk_i("t2_who2", acc_who[2], 0);
      chk_i("t2_who3", acc_who[3], 1);
      chk_i("t2_cyc1", acc_cyc[1], 6);
      chk_i("t2_cyc2", acc_cyc[2], 12);
      chk_i("t2_cyc3", acc_cyc[3], 18);
      chk_i("t2_ic_beats", ic_d.size(), 8);
      chk_i("t2_dc_beats", dc_d.size(), 8);
      for (int i = 0; i < 4; i++) begin
         chk_w($sformatf("t2_ic_data%0d", i), ic_d[i], DW'(128'h4A0 + i));
         chk_w($sformatf("t2_dc_data%0d", i), dc_d[i], DW'(128'h8A0 + i));
         chk_b($sformatf("t2_dc_last%0d", i), dc_l[i], (i == 3));
      end

      // Dcache writeback of line 0x040
      do_reset();
      q[0] = {4{32'h1111_1111}};
      q[1] = {4{32'h2222_2222}};
      q[2] = {4{32'h3333_3333}};
      q[3] = {4{32'h4444_4444}};
      dc_req_valid = 1'b1; dc_req_addr = 12'h040; dc_req_rtype = 1'b1;
      dc_req_wdata = {q[3], q[2], q[1], q[0]};
      wait_idle("t3", 30);
      chk_i("t3_accept_who", acc_who[0], 1);
      chk_i("t3_idle_cycle", cyc_n, 5);
      chk_i("t3_hs_count", hs_addr.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk_i($sformatf("t3_hs_addr%0d", i), int'(hs_addr[i]), 64 + i);
         chk_b($sformatf("t3_hs_we%0d", i), hs_we[i], 1'b1);
         chk_w($sformatf("t3_hs_wdata%0d", i), hs_wdata[i], q[i]);
      end
      chk_i("t3_ic_beats", ic_d.size(), 0);
      chk_i("t3_dc_beats", dc_d.size(), 0);

      // Read with mem_req_ready pattern 1,0,0,1,0,1,1
      do_reset();
      rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      ic_req_valid = 1'b1; ic_req_addr = 12'h052;
      wait_idle("t4", 40);
      chk_i("t4_hs_count", hs_addr.size(), 4);
      chk_i("t4_hs_cyc0", hs_cyc[0], 1);
      chk_i("t4_hs_cyc1", hs_cyc[1], 4);
      chk_i("t4_hs_cyc2", hs_cyc[2], 6);
      chk_i("t4_hs_cyc3", hs_cyc[3], 7);
      for (int i = 0; i < 4; i++) begin
         chk_i($sformatf("t4_hs_addr%0d", i), int'(hs_addr[i]), 80 + i);
         chk_w($sformatf("t4_ic_data%0d", i), ic_d[i], DW'(128'h10A0 + i));
      end
      chk_i("t4_idle_cycle", cyc_n, 9);

      // Unexpected response in IDLE
      mem_rsp_valid = 1'b1; mem_rsp_data = 128'hDEAD;
      #1;
      chk_b("t5_ic_rsp_valid", ic_rsp_valid, 1'b0);
      chk_b("t5_dc_rsp_valid", dc_rsp_valid, 1'b0);
      cyc();
      chk_b("t5_err_set", err_unexp_rsp, 1'b1);
      cyc();
      cyc();
      chk_b("t5_err_held", err_unexp_rsp, 1'b1);
      chk_i("t5_ic_beats", ic_d.size(), 4);
      rst = 1'b1;
      #1;
      chk_b("t5_err_cleared", err_unexp_rsp, 1'b0);
      do_reset();

      // Reset after two of four write beats, then a fresh writeback
      dc_req_valid = 1'b1; dc_req_addr = 12'h060; dc_req_rtype = 1'b1;
      dc_req_wdata = {4{128'h5555}};
      cyc();
      cyc();
      cyc();
      chk_i("t6_partial_hs", hs_addr.size(), 2);
      rst = 1'b1;
      #1;
      chk_b("t6_mem_valid_abort", mem_req_valid, 1'b0);
      chk_b("t6_busy_abort", busy, 1'b0);
      do_reset();
      dc_req_valid = 1'b1; dc_req_addr = 12'h071; dc_req_rtype = 1'b1;
      dc_req_wdata = {q[3], q[2], q[1], q[0]};
      wait_idle("t6", 30);
      chk_i("t6_hs_count", hs_addr.size(), 4);
      chk_i("t6_hs_cyc0", hs_cyc[0], 1);
      for (int i = 0; i < 4; i++) begin
         chk_i($sformatf("t6_hs_addr%0d", i), int'(hs_addr[i]), 112 + i);
         chk_w($sformatf("t6_hs_wdata%0d", i), hs_wdata[i], q[i]);
      end
      chk_i("t6_idle_cycle", cyc_n, 5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
